// File: rtl/buffer_tb_pkg.sv
// rtl/buffer_tb_pkg.sv - shared types, widths and run-length helper for the buffer throughput bench
package buffer_tb_pkg;

  localparam int BRA_CNT_W = 16;

  typedef enum logic [1:0] {
    BRA_IDLE  = 2'd0,
    BRA_BURST = 2'd1,
    BRA_GAP   = 2'd2,
    BRA_DONE  = 2'd3
  } bra_state_e;

  // Cycles from first BURST cycle to first DONE cycle when the FIFO never runs dry.
  function automatic int ideal_run_length(input int bursts, input int size, input int idle);
    return bursts * size + (bursts - 1) * idle;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at all-ones instead of wrapping
module sat_counter
  import buffer_tb_pkg::*;
#(
  parameter int W = BRA_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over increment so a counter can be restarted on the same cycle it counts.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/burst_read_agent.sv
// rtl/burst_read_agent.sv - bursty FIFO read-side traffic generator with read and stall accounting
module burst_read_agent
  import buffer_tb_pkg::*;
#(
  parameter int BURST_SIZE       = 10,
  parameter int IDLE_CYCLES      = 10,
  parameter int NUMBER_OF_BURSTS = 10,
  parameter int STALL_TIMEOUT    = 1024,
  parameter int CNT_W            = BRA_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             rrdy_i,
  output logic             re_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] rd_count_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST_SIZE - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(NUMBER_OF_BURSTS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);

  bra_state_e state_q, state_d;
  logic       timeout_q, timeout_d;

  logic [CNT_W-1:0] rd_cnt, stall_cnt, cons_cnt, beat_cnt, burst_idx, gap_cnt, run_cyc;

  logic start_ok, rd, stall, burst_end, run_end, stall_abort, in_gap, gap_end, busy;

  assign start_ok    = start_i && ((state_q == BRA_IDLE) || (state_q == BRA_DONE));
  assign rd          = (state_q == BRA_BURST) && rrdy_i;
  assign stall       = (state_q == BRA_BURST) && !rrdy_i;
  assign burst_end   = rd && (beat_cnt == BEAT_LAST);
  assign run_end     = burst_end && (burst_idx == BURST_LAST);
  assign stall_abort = stall && (cons_cnt == STALL_LAST);
  assign in_gap      = (state_q == BRA_GAP);
  assign gap_end     = in_gap && (gap_cnt == GAP_LAST);
  assign busy        = (state_q == BRA_BURST) || in_gap;

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start_ok), .en_i(rd), .count_o(rd_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start_ok), .en_i(stall), .count_o(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cons_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start_ok || rd), .en_i(stall), .count_o(cons_cnt)
  );

  sat_counter #(.W(CNT_W)) u_beat_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start_ok || burst_end), .en_i(rd), .count_o(beat_cnt)
  );

  sat_counter #(.W(CNT_W)) u_burst_idx (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start_ok), .en_i(burst_end), .count_o(burst_idx)
  );

  sat_counter #(.W(CNT_W)) u_gap_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start_ok || gap_end), .en_i(in_gap), .count_o(gap_cnt)
  );

  // Busy-cycle count of the current run; only feeds the run-length self check below.
  sat_counter #(.W(CNT_W)) u_run_cyc (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start_ok), .en_i(busy), .count_o(run_cyc)
  );

  // Next-state logic; stall abort and burst completion cannot coincide since one needs rrdy low, the other high.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      BRA_IDLE, BRA_DONE: begin
        if (start_i) begin
          state_d   = BRA_BURST;
          timeout_d = 1'b0;
        end
      end
      BRA_BURST: begin
        if (stall_abort) begin
          state_d   = BRA_DONE;
          timeout_d = 1'b1;
        end else if (run_end) begin
          state_d = BRA_DONE;
        end else if (burst_end && (IDLE_CYCLES != 0)) begin
          state_d = BRA_GAP;
        end
      end
      BRA_GAP: begin
        if (gap_end) begin
          state_d = BRA_BURST;
        end
      end
      default: state_d = BRA_IDLE;
    endcase
  end

  // State and abort-flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= BRA_IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // A stall-free run must finish in exactly the ideal number of cycles.
  always @(posedge clk_i) begin
    if (!rst_i && run_end && (stall_cnt == '0) && (run_cyc != '1)) begin
      assert (int'(run_cyc) + 1 == ideal_run_length(NUMBER_OF_BURSTS, BURST_SIZE, IDLE_CYCLES));
    end
  end

  assign re_o          = rd;
  assign busy_o        = busy;
  assign done_o        = (state_q == BRA_DONE);
  assign timeout_o     = timeout_q;
  assign rd_count_o    = rd_cnt;
  assign stall_count_o = stall_cnt;

endmodule

// File: tb/tb_burst_read_agent.sv
// tb/tb_burst_read_agent.sv - scoreboard bench for burst_read_agent across four parameter sets
module tb_burst_read_agent;
  import buffer_tb_pkg::*;

  typedef struct {
    int inst;
    int rd;
    int stall;
    int tmo;
    int len;
    int run;
  } exp_t;

  logic        clk = 1'b0;
  logic [3:0]  rst_s = 4'hf;
  logic [3:0]  start_s = 4'h0;
  logic [3:0]  rrdy_s = 4'b0111;
  logic [3:0]  re_s, busy_s, done_s, to_s;
  logic [15:0] rdc_s [4];
  logic [15:0] stc_s [4];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int entry_cyc [4];
  int cur_run   [4];
  int min_run   [4];
  int max_run   [4];
  logic [3:0] prev_busy = 4'h0;
  logic [3:0] prev_done = 4'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  burst_read_agent u_def (
    .clk_i(clk), .rst_i(rst_s[0]), .start_i(start_s[0]), .rrdy_i(rrdy_s[0]),
    .re_o(re_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]), .timeout_o(to_s[0]),
    .rd_count_o(rdc_s[0]), .stall_count_o(stc_s[0])
  );

  burst_read_agent #(.BURST_SIZE(4), .IDLE_CYCLES(2), .NUMBER_OF_BURSTS(2)) u_stl (
    .clk_i(clk), .rst_i(rst_s[1]), .start_i(start_s[1]), .rrdy_i(rrdy_s[1]),
    .re_o(re_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]), .timeout_o(to_s[1]),
    .rd_count_o(rdc_s[1]), .stall_count_o(stc_s[1])
  );

  burst_read_agent #(.BURST_SIZE(3), .IDLE_CYCLES(0), .NUMBER_OF_BURSTS(3)) u_b2b (
    .clk_i(clk), .rst_i(rst_s[2]), .start_i(start_s[2]), .rrdy_i(rrdy_s[2]),
    .re_o(re_s[2]), .busy_o(busy_s[2]), .done_o(done_s[2]), .timeout_o(to_s[2]),
    .rd_count_o(rdc_s[2]), .stall_count_o(stc_s[2])
  );

  burst_read_agent #(.BURST_SIZE(4), .IDLE_CYCLES(2), .NUMBER_OF_BURSTS(2), .STALL_TIMEOUT(8)) u_to (
    .clk_i(clk), .rst_i(rst_s[3]), .start_i(start_s[3]), .rrdy_i(rrdy_s[3]),
    .re_o(re_s[3]), .busy_o(busy_s[3]), .done_o(done_s[3]), .timeout_o(to_s[3]),
    .rd_count_o(rdc_s[3]), .stall_count_o(stc_s[3])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input int rd, input int stall, input int tmo,
                      input int len, input int run);
    exp_t e;
    e.inst = inst; e.rd = rd; e.stall = stall; e.tmo = tmo; e.len = len; e.run = run;
    sb.push_back(e);
  endtask

  task automatic pulse_start(input int idx);
    @(posedge clk); #1 start_s[idx] = 1'b1;
    @(posedge clk); #1 start_s[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int budget);
    int n = 0;
    while (!done_s[idx] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_s[idx]) chk($sformatf("done_wait_inst%0d", idx), 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: measures each run and pops the scoreboard when done_o rises.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (busy_s[i] && !prev_busy[i] && !rst_s[i]) begin
        entry_cyc[i] = cyc;
        cur_run[i]   = 0;
        min_run[i]   = 32'h7fffffff;
        max_run[i]   = 0;
      end
      if (re_s[i]) begin
        cur_run[i]++;
      end else if (cur_run[i] > 0) begin
        if (cur_run[i] < min_run[i]) min_run[i] = cur_run[i];
        if (cur_run[i] > max_run[i]) max_run[i] = cur_run[i];
        cur_run[i] = 0;
      end
      if (done_s[i] && !prev_done[i]) begin
        if (sb.size() == 0) begin
          chk($sformatf("unexpected_done_inst%0d", i), 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("sb_inst_%0d", i), i, e.inst);
          chk($sformatf("rd_count_inst%0d", i), int'(rdc_s[i]), e.rd);
          chk($sformatf("stall_count_inst%0d", i), int'(stc_s[i]), e.stall);
          chk($sformatf("timeout_inst%0d", i), int'(to_s[i]), e.tmo);
          chk($sformatf("run_len_inst%0d", i), cyc - entry_cyc[i], e.len);
          if (e.run >= 0) begin
            chk($sformatf("re_run_min_inst%0d", i), min_run[i], e.run);
            chk($sformatf("re_run_max_inst%0d", i), max_run[i], e.run);
          end
        end
      end
      prev_busy[i] = busy_s[i];
      prev_done[i] = done_s[i];
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_s = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_re_inst%0d", i), int'(re_s[i]), 0);
      chk($sformatf("rst_busy_inst%0d", i), int'(busy_s[i]), 0);
      chk($sformatf("rst_done_inst%0d", i), int'(done_s[i]), 0);
      chk($sformatf("rst_timeout_inst%0d", i), int'(to_s[i]), 0);
      chk($sformatf("rst_rd_inst%0d", i), int'(rdc_s[i]), 0);
      chk($sformatf("rst_stall_inst%0d", i), int'(stc_s[i]), 0);
    end

    // Ideal drain with defaults.
    push(0, 100, 0, 0, 190, 10);
    pulse_start(0);
    wait_done(0, 400);

    // Three-cycle stall after two reads of burst 1.
    push(1, 8, 3, 0, 13, -1);
    pulse_start(1);
    repeat (2) @(posedge clk);
    #1 rrdy_s[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rrdy_s[1] = 1'b1;
    wait_done(1, 100);

    // Back-to-back bursts: one unbroken 9-cycle read run.
    push(2, 9, 0, 0, ideal_run_length(3, 3, 0), 9);
    pulse_start(2);
    wait_done(2, 100);

    // FIFO empty from the start: abort after 8 stall cycles.
    push(3, 0, 8, 1, 8, -1);
    pulse_start(3);
    wait_done(3, 100);

    // Reset in the middle of a gap.
    pulse_start(1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("gap_busy", int'(busy_s[1]), 1);
    chk("gap_re", int'(re_s[1]), 0);
    chk("gap_rd_count", int'(rdc_s[1]), 4);
    @(posedge clk); #1 rst_s[1] = 1'b1;
    @(posedge clk); #1 rst_s[1] = 1'b0;
    @(negedge clk);
    chk("midrst_re", int'(re_s[1]), 0);
    chk("midrst_busy", int'(busy_s[1]), 0);
    chk("midrst_done", int'(done_s[1]), 0);
    chk("midrst_timeout", int'(to_s[1]), 0);
    chk("midrst_rd", int'(rdc_s[1]), 0);
    chk("midrst_stall", int'(stc_s[1]), 0);

    // A start pulse during BURST must not disturb the run.
    push(1, 8, 0, 0, 10, -1);
    pulse_start(1);
    @(posedge clk); #1 start_s[1] = 1'b1;
    @(posedge clk); #1 start_s[1] = 1'b0;
    wait_done(1, 100);

    // Restart from DONE clears the counters and runs again in full.
    push(1, 8, 0, 0, 10, -1);
    pulse_start(1);
    @(negedge clk);
    chk("restart_rd", int'(rdc_s[1]), 0);
    chk("restart_done", int'(done_s[1]), 0);
    chk("restart_busy", int'(busy_s[1]), 1);
    wait_done(1, 100);

    repeat (5) @(posedge clk);
    chk("sb_pending", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
